// File: rtl/unified_mem_if.sv
// Bus bundle for unified_mem: read-only fetch port plus read/write data port.
// The memory takes the slave side; the core (or a bench) drives the master side.
interface unified_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB = DATA_W / 8;

    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wen;
    logic [NB-1:0]     d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              busy;

    modport master (
        output i_addr, d_addr, d_wdata, d_wen, d_be,
        input  i_rdata, d_rdata, d_err, busy
    );

    modport slave (
        input  i_addr, d_addr, d_wdata, d_wen, d_be,
        output i_rdata, d_rdata, d_err, busy
    );
endinterface

// File: rtl/unified_mem.sv
// Unified instruction/data memory: fetch port, byte-enabled data port, and a
// post-reset clear sequencer that zeroes every word while busy is high.
module unified_mem #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned REG_READ  = 0,
    parameter int unsigned CLEAR_RST = 1
) (
    input  logic           clk,
    input  logic           rst,
    unified_mem_if.slave   bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e             state_q;
    logic [IDX_W:0]     clr_ptr_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               busy_c;
    logic [IDX_W-1:0]   i_idx, d_idx;
    logic               i_oor, d_oor, d_mis;
    logic               d_err_c, wr_en;
    logic [DATA_W-1:0]  i_word, d_word;

    always_comb begin
        busy_c  = (state_q == StClear);
        i_idx   = bus.i_addr[IDX_W+1:2];
        d_idx   = bus.d_addr[IDX_W+1:2];
        i_oor   = ((bus.i_addr >> (IDX_W + 2)) != '0);
        d_oor   = ((bus.d_addr >> (IDX_W + 2)) != '0);
        d_mis   = (bus.d_addr[1:0] != 2'b00);
        d_err_c = !busy_c && (d_oor || d_mis);
        wr_en   = rst && (state_q == StReady) && bus.d_wen && !d_err_c;
        i_word  = (busy_c || i_oor) ? '0 : mem_q[i_idx];
        d_word  = (busy_c || d_oor) ? '0 : mem_q[d_idx];
    end

    // Clear sequencer; clr_ptr has one spare bit so the exit compare sees DEPTH-1 before wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= (CLEAR_RST != 0) ? StClear : StReady;
            clr_ptr_q <= '0;
        end else if (state_q == StClear) begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
            if (clr_ptr_q == (IDX_W + 1)'(DEPTH - 1)) begin
                state_q <= StReady;
            end
        end
    end

    // Storage has no reset so contents survive reset when the clear is disabled.
    always_ff @(posedge clk) begin
        if (rst && (state_q == StClear)) begin
            mem_q[clr_ptr_q[IDX_W-1:0]] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (bus.d_be[k]) begin
                    mem_q[d_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
                end
            end
        end
    end

    assign bus.busy = busy_c;

    if (REG_READ != 0) begin : g_reg_read
        logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
        logic              d_err_q;

        // Captured before the write lands, so a same-edge write shows up one read later.
        always_ff @(posedge clk) begin
            if (!rst) begin
                i_rdata_q <= '0;
                d_rdata_q <= '0;
                d_err_q   <= 1'b0;
            end else begin
                i_rdata_q <= i_word;
                d_rdata_q <= d_word;
                d_err_q   <= d_err_c;
            end
        end

        assign bus.i_rdata = i_rdata_q;
        assign bus.d_rdata = d_rdata_q;
        assign bus.d_err   = d_err_q;
    end else begin : g_comb_read
        assign bus.i_rdata = i_word;
        assign bus.d_rdata = d_word;
        assign bus.d_err   = d_err_c;
    end
endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: dut_a default config, dut_b registered reads,
// dut_c without the post-reset clear.
module tb_unified_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    int n_cmp  = 0;
    int n_fail = 0;

    unified_mem_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    unified_mem_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();
    unified_mem_if #(.DATA_W(32), .ADDR_W(32)) bus_c ();

    unified_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .REG_READ(0), .CLEAR_RST(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a)
    );
    unified_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .REG_READ(1), .CLEAR_RST(1)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b)
    );
    unified_mem #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .REG_READ(0), .CLEAR_RST(0)) dut_c (
        .clk(clk), .rst(rst_c), .bus(bus_c)
    );

    task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus_a.d_addr  = addr;
        bus_a.d_wdata = data;
        bus_a.d_be    = be;
        bus_a.d_wen   = 1'b1;
        @(negedge clk);
        bus_a.d_wen   = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy_a: got %b want 1", bus_a.busy);
        end
        n_cmp++;
        if (bus_b.d_rdata !== 32'h0 || bus_b.i_rdata !== 32'h0 || bus_b.d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regout_b: got d=%h i=%h e=%b want 0/0/0",
                     bus_b.d_rdata, bus_b.i_rdata, bus_b.d_err);
        end
        n_cmp++;
        if (bus_c.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_c: got %b want 0", bus_c.busy);
        end
    endtask

    task automatic test_clear();
        int cnt;
        int bad;
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        cnt = 0;
        #1;
        while (bus_a.busy === 1'b1 && cnt < 1000) begin
            cnt++;
            if (cnt == 50) begin
                bus_a.d_addr  = 32'h40;
                bus_a.d_wdata = 32'hFFFF_FFFF;
                bus_a.d_be    = 4'hF;
                bus_a.d_wen   = 1'b1;
            end
            if (cnt == 51) bus_a.d_wen = 1'b0;
            @(negedge clk);
            #1;
        end
        bus_a.d_wen = 1'b0;
        n_cmp++;
        if (cnt != 256) begin
            n_fail++; $display("FAIL clear_busy_len: got %0d cycles want 256", cnt);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            bus_a.d_addr = 32'(i * 4);
            bus_a.i_addr = 32'(i * 4);
            #1;
            n_cmp++;
            if (bus_a.d_rdata !== 32'h0 || bus_a.i_rdata !== 32'h0 || bus_a.d_err !== 1'b0) begin
                n_fail++;
                if (bad < 8)
                    $display("FAIL clear_word[%0d]: got d=%h i=%h e=%b want 0/0/0", i,
                             bus_a.d_rdata, bus_a.i_rdata, bus_a.d_err);
                bad++;
            end
        end
    endtask

    task automatic test_byte_lanes();
        a_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        a_write(32'h10, 32'h1122_3344, 4'b0101);
        bus_a.d_addr = 32'h10;
        bus_a.i_addr = 32'h10;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL lanes_data: got %h want de22be44", bus_a.d_rdata);
        end
        n_cmp++;
        if (bus_a.i_rdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL lanes_fetch: got %h want de22be44", bus_a.i_rdata);
        end
        bus_a.i_addr = 32'h13;
        #1;
        n_cmp++;
        if (bus_a.i_rdata !== 32'hDE22_BE44) begin
            n_fail++; $display("FAIL fetch_low_bits: got %h want de22be44", bus_a.i_rdata);
        end
        a_write(32'h14, 32'h0BAD_F00D, 4'h0);
        bus_a.d_addr = 32'h14;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL be_zero_noop: got %h want 0", bus_a.d_rdata);
        end
    endtask

    task automatic test_errors();
        @(negedge clk);
        bus_a.d_addr  = 32'h12;
        bus_a.d_wdata = 32'h0;
        bus_a.d_be    = 4'hF;
        bus_a.d_wen   = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.d_err !== 1'b1) begin
            n_fail++; $display("FAIL misalign_err: got %b want 1", bus_a.d_err);
        end
        @(negedge clk);
        bus_a.d_wen  = 1'b0;
        bus_a.d_addr = 32'h10;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'hDE22_BE44 || bus_a.d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_dropped: got %h err=%b want de22be44 err=0",
                     bus_a.d_rdata, bus_a.d_err);
        end
        @(negedge clk);
        bus_a.d_addr  = 32'h400;
        bus_a.i_addr  = 32'h400;
        bus_a.d_wdata = 32'hCAFE_F00D;
        bus_a.d_wen   = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.d_err !== 1'b1 || bus_a.d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got d=%h err=%b want 0 err=1", bus_a.d_rdata, bus_a.d_err);
        end
        n_cmp++;
        if (bus_a.i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_fetch: got %h want 0", bus_a.i_rdata);
        end
        @(negedge clk);
        bus_a.d_wen  = 1'b0;
        bus_a.d_addr = 32'h0;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_no_alias: got %h want 0", bus_a.d_rdata);
        end
    endtask

    task automatic test_comb_rw();
        @(negedge clk);
        bus_a.d_addr  = 32'h30;
        bus_a.i_addr  = 32'h30;
        bus_a.d_wdata = 32'h1234_5678;
        bus_a.d_be    = 4'hF;
        bus_a.d_wen   = 1'b1;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'h0 || bus_a.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL comb_old_value: got d=%h i=%h want 0/0", bus_a.d_rdata, bus_a.i_rdata);
        end
        @(negedge clk);
        bus_a.d_wen = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'h1234_5678 || bus_a.i_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL comb_new_value: got d=%h i=%h want 12345678", bus_a.d_rdata,
                     bus_a.i_rdata);
        end
    endtask

    task automatic test_reg_read();
        int cnt;
        cnt = 0;
        while (bus_b.busy !== 1'b0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (bus_b.busy !== 1'b0) begin
            n_fail++; $display("FAIL regrd_ready: got busy=%b want 0", bus_b.busy);
        end
        @(negedge clk);
        bus_b.d_addr  = 32'h20;
        bus_b.i_addr  = 32'h20;
        bus_b.d_wdata = 32'hA5A5_A5A5;
        bus_b.d_be    = 4'hF;
        bus_b.d_wen   = 1'b1;
        @(negedge clk);
        bus_b.d_wen = 1'b0;
        #1;
        n_cmp++;
        if (bus_b.d_rdata !== 32'h0 || bus_b.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL regrd_old: got d=%h i=%h want 0/0", bus_b.d_rdata, bus_b.i_rdata);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus_b.d_rdata !== 32'hA5A5_A5A5 || bus_b.i_rdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL regrd_new: got d=%h i=%h want a5a5a5a5", bus_b.d_rdata,
                     bus_b.i_rdata);
        end
        bus_b.d_addr = 32'h22;
        #1;
        n_cmp++;
        if (bus_b.d_err !== 1'b0) begin
            n_fail++; $display("FAIL regrd_err_latency: got %b want 0", bus_b.d_err);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus_b.d_err !== 1'b1) begin
            n_fail++; $display("FAIL regrd_err: got %b want 1", bus_b.d_err);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        a_write(32'h44, 32'h0BAD_CAFE, 4'hF);
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        cnt = 0;
        #1;
        while (bus_a.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        rst_a = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL midclr_busy_in_rst: got %b want 1", bus_a.busy);
        end
        rst_a = 1'b1;
        cnt = 0;
        while (bus_a.busy === 1'b1 && cnt < 1000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (cnt != 256) begin
            n_fail++; $display("FAIL midclr_busy_len: got %0d cycles want 256", cnt);
        end
        bus_a.d_addr = 32'h44;
        bus_a.i_addr = 32'h10;
        #1;
        n_cmp++;
        if (bus_a.d_rdata !== 32'h0 || bus_a.i_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midclr_wiped: got d=%h i=%h want 0/0", bus_a.d_rdata, bus_a.i_rdata);
        end
    endtask

    task automatic test_no_clear();
        @(negedge clk);
        bus_c.d_addr  = 32'h8;
        bus_c.d_wdata = 32'h5;
        bus_c.d_be    = 4'hF;
        bus_c.d_wen   = 1'b1;
        @(negedge clk);
        bus_c.d_wen = 1'b0;
        rst_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) rst_c = 1'b1;
            #1;
            n_cmp++;
            if (bus_c.busy !== 1'b0) begin
                n_fail++; $display("FAIL noclr_busy[%0d]: got %b want 0", i, bus_c.busy);
            end
        end
        bus_c.i_addr = 32'h8;
        #1;
        n_cmp++;
        if (bus_c.d_rdata !== 32'h5 || bus_c.i_rdata !== 32'h5) begin
            n_fail++;
            $display("FAIL noclr_kept: got d=%h i=%h want 5", bus_c.d_rdata, bus_c.i_rdata);
        end
    endtask

    initial begin
        bus_a.i_addr = '0; bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_wen = 1'b0;
        bus_a.d_be = '0;
        bus_b.i_addr = '0; bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_wen = 1'b0;
        bus_b.d_be = '0;
        bus_c.i_addr = '0; bus_c.d_addr = '0; bus_c.d_wdata = '0; bus_c.d_wen = 1'b0;
        bus_c.d_be = '0;
        test_reset();
        test_clear();
        test_byte_lanes();
        test_errors();
        test_comb_rw();
        test_reg_read();
        test_reset_mid_clear();
        test_no_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
